// File: rtl/mem_arbiter_if.sv
// Bundles the fetch, data and memory sides of the two-requester memory arbiter.
// The arbiter takes the slave view; the requesters and memory model take the master view.
interface mem_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        if_stall;

  logic        dm_ren;
  logic        dm_wen;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_ack;
  logic [31:0] dm_rdata;
  logic        dm_stall;

  logic        mem_cs;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic [31:0] mem_dout;
  logic        mem_ack;
  logic        mem_err;

  modport slave (
    input  if_req, if_addr, dm_ren, dm_wen, dm_addr, dm_wdata, mem_dout, mem_ack,
    output if_ack, if_rdata, if_stall, dm_ack, dm_rdata, dm_stall,
           mem_cs, mem_we, mem_addr, mem_din, mem_err
  );

  modport master (
    output if_req, if_addr, dm_ren, dm_wen, dm_addr, dm_wdata, mem_dout, mem_ack,
    input  if_ack, if_rdata, if_stall, dm_ack, dm_rdata, dm_stall,
           mem_cs, mem_we, mem_addr, mem_din, mem_err
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch and data access,
// with a watchdog that aborts an access the memory never acknowledges.
module mem_arbiter #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StIfAcc, StDmAcc, StDone} state_e;

  state_e      state_q, state_d;
  logic        grant_dm_q, grant_dm_d;  // last grant: 1 = data side, 0 = fetch side
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic        err_q, err_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] dm_rdata_q, dm_rdata_d;

  logic        dm_pend;
  logic        if_pend;
  logic        in_acc;
  logic        in_done;
  logic        finish;
  logic [31:0] cap_val;

  assign dm_pend = bus.dm_ren | bus.dm_wen;
  assign if_pend = bus.if_req;
  assign in_acc  = (state_q == StIfAcc) || (state_q == StDmAcc);
  assign in_done = (state_q == StDone);

  always_comb begin
    state_d    = state_q;
    grant_dm_d = grant_dm_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    err_d      = err_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    finish     = 1'b0;
    cap_val    = 32'h0;

    unique case (state_q)
      StIdle: begin
        if (dm_pend && (!if_pend || !grant_dm_q)) begin
          state_d    = StDmAcc;
          grant_dm_d = 1'b1;
          cnt_d      = 4'd0;
          addr_d     = bus.dm_addr;
          wdata_d    = bus.dm_wdata;
          we_d       = bus.dm_wen;
        end else if (if_pend) begin
          state_d    = StIfAcc;
          grant_dm_d = 1'b0;
          cnt_d      = 4'd0;
          addr_d     = bus.if_addr;
          wdata_d    = 32'h0;
          we_d       = 1'b0;
        end
      end
      StIfAcc, StDmAcc: begin
        // A memory ack on the final watchdog cycle still wins over the abort.
        if (bus.mem_ack) begin
          finish  = 1'b1;
          err_d   = 1'b0;
          cap_val = bus.mem_dout;
        end else begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_d == 4'(TIMEOUT)) begin
            finish  = 1'b1;
            err_d   = 1'b1;
            cap_val = 32'h0;
          end
        end
        if (finish) begin
          state_d = StDone;
          if (state_q == StIfAcc) begin
            if_rdata_d = cap_val;
          end else if (!we_q) begin
            dm_rdata_d = cap_val;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      grant_dm_q <= 1'b0;
      cnt_q      <= 4'd0;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      we_q       <= 1'b0;
      err_q      <= 1'b0;
      if_rdata_q <= 32'h0;
      dm_rdata_q <= 32'h0;
    end else begin
      state_q    <= state_d;
      grant_dm_q <= grant_dm_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      err_q      <= err_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
    end
  end

  assign bus.mem_cs   = in_acc;
  assign bus.mem_we   = (state_q == StDmAcc) & we_q;
  assign bus.mem_addr = addr_q;
  assign bus.mem_din  = wdata_q;
  assign bus.mem_err  = in_done & err_q;
  assign bus.if_ack   = in_done & ~grant_dm_q;
  assign bus.dm_ack   = in_done & grant_dm_q;
  assign bus.if_rdata = if_rdata_q;
  assign bus.dm_rdata = dm_rdata_q;
  assign bus.if_stall = bus.if_req & ~bus.if_ack;
  assign bus.dm_stall = dm_pend & ~bus.dm_ack;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios with literal expectations plus randomized traffic,
// all checked each cycle against a transaction-level model of the arbiter.
module tb_mem_arbiter;
  localparam int unsigned TIMEOUT = 15;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_arbiter_if bus ();

  mem_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Transaction-level model: phase 0 = no access, 1 = memory busy, 2 = completion cycle.
  bit          model_on = 1'b0;
  int          m_phase  = 0;
  bit          m_dm, m_we, m_err, m_prefer_dm;
  int          m_wait;
  logic [31:0] m_addr, m_wdata, m_if_rd, m_dm_rd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %08h required %08h", name, act, exp);
  endtask

  task automatic model_step();
    bit dmp, ifp;
    if (rst) begin
      model_on    = 1'b1;
      m_phase     = 0;
      m_prefer_dm = 1'b1;
      m_dm        = 1'b0;
      m_we        = 1'b0;
      m_err       = 1'b0;
      m_addr      = 32'h0;
      m_wdata     = 32'h0;
      m_if_rd     = 32'h0;
      m_dm_rd     = 32'h0;
      return;
    end
    if (!model_on) return;
    case (m_phase)
      0: begin
        dmp = bus.dm_ren || bus.dm_wen;
        ifp = bus.if_req;
        if (dmp || ifp) begin
          m_dm        = dmp && (!ifp || m_prefer_dm);
          m_prefer_dm = !m_dm;
          m_addr      = m_dm ? bus.dm_addr : bus.if_addr;
          m_we        = m_dm && bus.dm_wen;
          m_wdata     = bus.dm_wdata;
          m_wait      = 0;
          m_phase     = 1;
        end
      end
      1: begin
        if (bus.mem_ack) begin
          m_err = 1'b0;
          if (!m_dm) m_if_rd = bus.mem_dout;
          else if (!m_we) m_dm_rd = bus.mem_dout;
          m_phase = 2;
        end else begin
          m_wait++;
          if (m_wait == int'(TIMEOUT)) begin
            m_err = 1'b1;
            if (!m_dm) m_if_rd = 32'h0;
            else if (!m_we) m_dm_rd = 32'h0;
            m_phase = 2;
          end
        end
      end
      default: m_phase = 0;
    endcase
  endtask

  task automatic compare();
    bit e_if_ack, e_dm_ack;
    e_if_ack = (m_phase == 2) && !m_dm;
    e_dm_ack = (m_phase == 2) && m_dm;
    chk("m_mem_cs", bus.mem_cs, m_phase == 1);
    chk("m_mem_we", bus.mem_we, (m_phase == 1) && m_we);
    if (m_phase == 1) chk("m_mem_addr", bus.mem_addr, m_addr);
    if (m_phase == 1 && m_we) chk("m_mem_din", bus.mem_din, m_wdata);
    chk("m_if_ack", bus.if_ack, e_if_ack);
    chk("m_dm_ack", bus.dm_ack, e_dm_ack);
    chk("m_mem_err", bus.mem_err, (m_phase == 2) && m_err);
    chk("m_if_rdata", bus.if_rdata, m_if_rd);
    chk("m_dm_rdata", bus.dm_rdata, m_dm_rd);
    chk("m_if_stall", bus.if_stall, bus.if_req && !e_if_ack);
    chk("m_dm_stall", bus.dm_stall, (bus.dm_ren || bus.dm_wen) && !e_dm_ack);
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (model_on) compare();
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.if_req   = 1'b0;
    bus.dm_ren   = 1'b0;
    bus.dm_wen   = 1'b0;
    bus.mem_ack  = 1'b0;
  endtask

  // One request held until acked; memory acks after `delay` busy cycles (-1 = never).
  task automatic access(input bit dm, input bit wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input int delay, input logic [31:0] dout,
                        output int cs_n, output int we_n, output int ack_n, output int err_n,
                        output logic [31:0] din0);
    cs_n = 0; we_n = 0; ack_n = 0; err_n = 0; din0 = 32'h0;
    tick();
    if (dm) begin
      bus.dm_ren   = !wr;
      bus.dm_wen   = wr;
      bus.dm_addr  = addr;
      bus.dm_wdata = wdata;
    end else begin
      bus.if_req  = 1'b1;
      bus.if_addr = addr;
    end
    bus.mem_ack  = (delay == 0);
    bus.mem_dout = dout;
    for (int i = 0; i < 40 && ack_n == 0; i++) begin
      @(negedge clk);
      if (bus.mem_cs) begin
        if (cs_n == 0) din0 = bus.mem_din;
        cs_n++;
      end
      if (bus.mem_we) we_n++;
      if (dm ? bus.dm_ack : bus.if_ack) begin
        ack_n++;
        if (bus.mem_err) err_n++;
      end
      tick();
      bus.mem_ack = (delay >= 0) && (cs_n == delay);
    end
    idle_inputs();
  endtask

  task automatic contention();
    logic [31:0] seq[$];
    logic [31:0] exp_seq [4];
    exp_seq = '{32'h20, 32'h10, 32'h20, 32'h10};
    tick();
    rst          = 1'b1;
    bus.if_req   = 1'b1;
    bus.if_addr  = 32'h10;
    bus.dm_ren   = 1'b1;
    bus.dm_addr  = 32'h20;
    bus.mem_ack  = 1'b1;
    bus.mem_dout = 32'h5555_AAAA;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 30 && seq.size() < 4; i++) begin
      @(negedge clk);
      if (bus.mem_cs) seq.push_back(bus.mem_addr);
      tick();
    end
    idle_inputs();
    chk("d_grant_count", seq.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < seq.size()) chk("d_grant_order", seq[i], exp_seq[i]);
    end
  endtask

  task automatic random_traffic();
    int ack_pct;
    for (int blk = 0; blk < 6; blk++) begin
      ack_pct = (blk % 3 == 0) ? 50 : ((blk % 3 == 1) ? 10 : 0);
      for (int c = 0; c < 60; c++) begin
        tick();
        rst          = ($urandom_range(0, 99) == 0);
        bus.if_req   = ($urandom_range(0, 99) < 40);
        bus.dm_ren   = ($urandom_range(0, 99) < 30);
        bus.dm_wen   = ($urandom_range(0, 99) < 20);
        bus.if_addr  = $urandom;
        bus.dm_addr  = $urandom;
        bus.dm_wdata = $urandom;
        bus.mem_dout = $urandom;
        bus.mem_ack  = ($urandom_range(0, 99) < ack_pct);
      end
    end
    tick();
    rst = 1'b0;
    idle_inputs();
    tick();
    tick();
  endtask

  initial begin
    int cs_n, we_n, ack_n, err_n;
    logic [31:0] din0;
    rst          = 1'b1;
    bus.if_addr  = 32'h0;
    bus.dm_addr  = 32'h0;
    bus.dm_wdata = 32'h0;
    bus.mem_dout = 32'h0;
    idle_inputs();
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_cs", bus.mem_cs, 0);
    chk("rst_if_rdata", bus.if_rdata, 0);
    chk("rst_dm_rdata", bus.dm_rdata, 0);

    // Lone fetch, then the same request held through the completion cycle.
    tick();
    bus.if_req   = 1'b1;
    bus.if_addr  = 32'h40;
    bus.mem_ack  = 1'b1;
    bus.mem_dout = 32'h8C01_0004;
    @(negedge clk);
    chk("a_stall_req", bus.if_stall, 1);
    chk("a_cs_req", bus.mem_cs, 0);
    tick();
    @(negedge clk);
    chk("a_cs_acc", bus.mem_cs, 1);
    chk("a_addr", bus.mem_addr, 32'h40);
    chk("a_we_acc", bus.mem_we, 0);
    chk("a_stall_acc", bus.if_stall, 1);
    tick();
    @(negedge clk);
    chk("a_ack", bus.if_ack, 1);
    chk("a_rdata", bus.if_rdata, 32'h8C01_0004);
    chk("a_cs_done", bus.mem_cs, 0);
    chk("a_stall_done", bus.if_stall, 0);
    tick();
    @(negedge clk);
    chk("hold_no_regrant", bus.mem_cs, 0);
    chk("hold_no_ack", bus.if_ack, 0);
    tick();
    @(negedge clk);
    chk("hold_regrant", bus.mem_cs, 1);
    tick();
    bus.if_req = 1'b0;
    @(negedge clk);
    chk("hold_ack2", bus.if_ack, 1);
    idle_inputs();

    access(1'b1, 1'b1, 32'h100, 32'h1234, 3, 32'hFFFF_0000, cs_n, we_n, ack_n, err_n, din0);
    chk("b_cs_cycles", cs_n, 4);
    chk("b_we_cycles", we_n, 4);
    chk("b_din", din0, 32'h1234);
    chk("b_ack", ack_n, 1);
    chk("b_err", err_n, 0);
    chk("b_rdata_kept", bus.dm_rdata, 0);

    access(1'b1, 1'b0, 32'h200, 32'h0, 1, 32'hDEAD_BEEF, cs_n, we_n, ack_n, err_n, din0);
    chk("c_read_cs", cs_n, 2);
    chk("c_read_rdata", bus.dm_rdata, 32'hDEAD_BEEF);

    access(1'b1, 1'b0, 32'h204, 32'h0, -1, 32'h7777_7777, cs_n, we_n, ack_n, err_n, din0);
    chk("c_to_cs", cs_n, 15);
    chk("c_to_ack", ack_n, 1);
    chk("c_to_err", err_n, 1);
    chk("c_to_rdata", bus.dm_rdata, 0);

    access(1'b0, 1'b0, 32'h300, 32'h0, 0, 32'h1111_2222, cs_n, we_n, ack_n, err_n, din0);
    chk("c_after_cs", cs_n, 1);
    chk("c_after_err", err_n, 0);
    chk("c_after_rdata", bus.if_rdata, 32'h1111_2222);

    access(1'b1, 1'b0, 32'h400, 32'h0, 14, 32'h0000_CAFE, cs_n, we_n, ack_n, err_n, din0);
    chk("edge_cs", cs_n, 15);
    chk("edge_ack", ack_n, 1);
    chk("edge_err", err_n, 0);
    chk("edge_rdata", bus.dm_rdata, 32'h0000_CAFE);

    contention();

    // Reset during the second busy cycle of a fetch, then a stray memory ack.
    tick();
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h80;
    bus.mem_ack = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("e_cs_acc2", bus.mem_cs, 1);
    tick();
    rst          = 1'b0;
    bus.if_req   = 1'b0;
    bus.mem_ack  = 1'b1;
    bus.mem_dout = 32'hBAD0_BAD0;
    @(negedge clk);
    chk("e_cs_after", bus.mem_cs, 0);
    chk("e_no_ack", bus.if_ack, 0);
    tick();
    @(negedge clk);
    chk("e_no_ack2", bus.if_ack, 0);
    chk("e_cs_late", bus.mem_cs, 0);
    chk("e_rdata", bus.if_rdata, 0);
    tick();
    idle_inputs();

    random_traffic();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have ports, clock and reset first: clk in 1, system clock, rising edge; rst in 1, reset, synchronous, active-high.
REQ-002 SHALL have IF-side ports: if_req in 1 (fetch request); if_addr in 32; if_ack out 1 (one-cycle done pulse); if_rdata out 32; if_stall out 1.
REQ-003 SHALL have data-side ports: dm_ren in 1; dm_wen in 1; dm_addr in 32; dm_wdata in 32; dm_ack out 1; dm_rdata out 32; dm_stall out 1.
REQ-004 SHALL have memory-side ports: mem_cs out 1; mem_we out 1; mem_addr out 32; mem_din out 32 (write data); mem_dout in 32 (read data); mem_ack in 1 (access complete, any latency >=0 cycles after mem_cs).
REQ-005 SHALL have mem_err out 1, pulsed with ack on watchdog timeout.
REQ-006 SHALL have parameter TIMEOUT, default 15, giving the maximum ACC-state cycles before abort.

Function
REQ-007 SHALL implement FSM states IDLE, IF_ACC, DM_ACC and DONE, with state registered.
REQ-008 SHALL, in IDLE, select dm_pend = dm_ren|dm_wen and if_pend = if_req; the next state SHALL be DM_ACC if dm_pend and (not if_pend or last_grant==IF), else IF_ACC if if_pend, else IDLE.
REQ-009 SHALL update the last_grant register (reset value IF) on every IDLE->ACC transition, so that under continuous contention the grants alternate DM, IF, DM, IF.
REQ-010 SHALL latch addr, wdata and we (we = dm_wen; dm_wen together with dm_ren is a write) on the IDLE->ACC edge; mem_addr, mem_din and mem_we SHALL be driven only from these latches.
REQ-011 SHALL assert mem_cs=1 in IF_ACC and DM_ACC only; mem_we SHALL be 0 in IF_ACC and in all other non-ACC states.
REQ-012 SHALL, in an ACC state with mem_ack=1, capture mem_dout into the granted requester's rdata register (DM write: rdata unchanged) and go to DONE.
REQ-013 SHALL, in DONE, assert exactly the granted requester's ack for one cycle, then return to IDLE unconditionally; a request still held high during DONE SHALL NOT be re-granted in DONE.
REQ-014 SHALL hold if_rdata and dm_rdata stable from the ack cycle until the next completed read on that port.
REQ-015 SHALL implement a watchdog: a 4-bit counter cleared on ACC entry and incremented each ACC cycle without mem_ack; at count==TIMEOUT, go to DONE with mem_err=1 in the DONE cycle, the capture value forced to 32'h0, and mem_cs dropped.
REQ-016 SHALL, if mem_ack coincides with count==TIMEOUT, treat the access as successful (mem_err=0).
REQ-017 SHALL ignore mem_ack outside the ACC states.
REQ-018 SHALL drive if_stall = if_req & ~if_ack and dm_stall = (dm_ren|dm_wen) & ~dm_ack combinationally from the registered acks.
REQ-019 SHALL have a minimum latency from request to ack of 2 cycles (grant edge, mem_ack in the first ACC cycle, DONE).
REQ-020 SHALL give back-to-back accesses to the same port a 3-cycle minimum period (ACC, DONE, IDLE).

Reset
REQ-021 SHALL, on rst (synchronous, overriding all else, including mid-access), set state=IDLE, last_grant=IF, counter=0, latches=0, if_rdata=dm_rdata=0, and all outputs 0 (mem_cs, mem_we, if_ack, dm_ack, mem_err).
REQ-022 SHALL issue no ack for an access aborted by reset.

Verification
REQ-023 SHALL cover a lone fetch: if_req=1, if_addr=0x40, mem_ack on the 1st ACC cycle with mem_dout=0x8C010004 -> mem_cs high 1 cycle, if_ack pulse 2 cycles after the request, if_rdata=0x8C010004, if_stall high for 2 cycles.
REQ-024 SHALL cover contention: if_req and dm_ren held from reset, mem_ack immediate -> grant order DM, IF, DM, IF; no port waits more than one other access.
REQ-025 SHALL cover a store: dm_wen=1, dm_addr=0x100, dm_wdata=0x1234, mem_ack after 3 cycles -> mem_we=mem_cs=1 for 4 cycles, mem_din=0x1234, dm_ack pulse, dm_rdata unchanged.
REQ-026 SHALL cover a timeout: dm_ren with mem_ack never asserted -> mem_cs high for 15 cycles, then dm_ack and mem_err pulse together, dm_rdata=0; a subsequent if_req is served normally.
REQ-027 SHALL cover reset mid-access: rst in the 2nd IF_ACC cycle -> next cycle mem_cs=0, state IDLE, no if_ack; a late mem_ack is ignored.
REQ-028 SHALL cover a request held through DONE: a requester keeps its request high in the DONE cycle -> no re-grant in DONE, and a new grant is issued from the following IDLE cycle.
